// File: rtl/idct_pkg.sv
// idct_pkg: shared widths, zigzag-to-raster table and quant-matrix reset value.
package idct_pkg;
  localparam int WCOEF = 12;
  localparam int WIN = 12;
  localparam int WQ = 8;
  localparam int WQS = 5;
  localparam logic [WQ-1:0] QMAT_RESET = 8'd16;
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };
endpackage

// File: rtl/dequant_unit.sv
// dequant_unit: coef * q * qs, arithmetic shift right by 4, saturate to WIN bits.
module dequant_unit
  import idct_pkg::*;
#(
  parameter int WC = WCOEF,
  parameter int WO = WIN,
  parameter int WM = WQ,
  parameter int WS = WQS
) (
  input  logic signed [WC-1:0] coef,
  input  logic        [WM-1:0] q,
  input  logic        [WS-1:0] qs,
  output logic signed [WO-1:0] val
);
  localparam int WP = WC + WM + WS + 1;
  localparam logic signed [WP-1:0] MAXV = {{(WP-WO+1){1'b0}}, {(WO-1){1'b1}}};
  localparam logic signed [WP-1:0] MINV = ~MAXV;
  logic signed [WP-1:0] prod, shr;
  assign prod = WP'(coef) * WP'($signed({1'b0, q})) * WP'($signed({1'b0, qs}));
  assign shr = prod >>> 4;
  assign val = (shr > MAXV) ? MAXV[WO-1:0] : (shr < MINV) ? MINV[WO-1:0] : shr[WO-1:0];
endmodule

// File: rtl/axi_stream_dequant_zigzag.sv
// axi_stream_dequant_zigzag: dequantize zigzag-ordered coefficients and emit
// raster-ordered 8x8 blocks through a ping-pong buffer.
module axi_stream_dequant_zigzag
  import idct_pkg::*;
#(
  parameter int WC = WCOEF,
  parameter int WO = WIN,
  parameter int WM = WQ,
  parameter int WS = WQS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [WC-1:0] slave_tdata,
  input  logic                 slave_tvalid,
  output logic                 slave_tready,
  input  logic        [WS-1:0] qscale,
  input  logic                 qmat_we,
  input  logic        [5:0]    qmat_addr,
  input  logic        [WM-1:0] qmat_data,
  output logic signed [WO-1:0] master_tdata,
  output logic                 master_tvalid,
  input  logic                 master_tready
);
  logic [WO-1:0] bank [2][64];
  logic [WM-1:0] qmat [64];
  logic [1:0] full, set, clr;
  logic wb, rb, in_hs, out_hs;
  logic [5:0] in_cnt, out_cnt;
  logic [WS-1:0] qs_blk;
  logic signed [WO-1:0] val;
  assign slave_tready = ~full[wb];
  assign in_hs = slave_tvalid & slave_tready;
  assign master_tvalid = full[rb];
  assign out_hs = master_tvalid & master_tready;
  assign master_tdata = master_tvalid ? bank[rb][out_cnt] : '0;
  // write and read completions always target different banks, so both may apply
  assign set = {2{in_hs & (&in_cnt)}} & (wb ? 2'b10 : 2'b01);
  assign clr = {2{out_hs & (&out_cnt)}} & (rb ? 2'b10 : 2'b01);
  dequant_unit #(.WC(WC), .WO(WO), .WM(WM), .WS(WS)) u_dq (
    .coef(slave_tdata),
    .q(qmat[in_cnt]),
    .qs(in_cnt == '0 ? qscale : qs_blk),
    .val
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 64; i++) bank[b][i] <= '0;
      for (int i = 0; i < 64; i++) qmat[i] <= QMAT_RESET;
      full <= '0;
      wb <= 1'b0;
      rb <= 1'b0;
      in_cnt <= '0;
      out_cnt <= '0;
      qs_blk <= '0;
    end else begin
      if (qmat_we) qmat[qmat_addr] <= qmat_data;
      if (in_hs) begin
        bank[wb][ZZ[in_cnt]] <= val;
        in_cnt <= in_cnt + 6'd1;
        if (in_cnt == '0) qs_blk <= qscale;
        if (&in_cnt) wb <= ~wb;
      end
      if (out_hs) begin
        out_cnt <= out_cnt + 6'd1;
        if (&out_cnt) rb <= ~rb;
      end
      full <= (full & ~clr) | set;
    end
  end
endmodule

// File: tb/tb_axi_stream_dequant_zigzag.sv
// tb_axi_stream_dequant_zigzag: directed + random stimulus checked against an
// arithmetic reference model with a generated zigzag walk.
module tb_axi_stream_dequant_zigzag;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [11:0] slave_tdata = '0;
  logic slave_tvalid = 1'b0;
  logic slave_tready;
  logic [4:0] qscale = '0;
  logic qmat_we = 1'b0;
  logic [5:0] qmat_addr = '0;
  logic [7:0] qmat_data = '0;
  logic signed [11:0] master_tdata;
  logic master_tvalid;
  logic master_tready = 1'b0;

  always #5 clk = ~clk;

  axi_stream_dequant_zigzag dut (
    .clk(clk), .rst(rst),
    .slave_tdata(slave_tdata), .slave_tvalid(slave_tvalid), .slave_tready(slave_tready),
    .qscale(qscale), .qmat_we(qmat_we), .qmat_addr(qmat_addr), .qmat_data(qmat_data),
    .master_tdata(master_tdata), .master_tvalid(master_tvalid), .master_tready(master_tready)
  );

  int errors = 0;
  int checks = 0;
  int zz [64];
  int m_qmat [64];
  int m_qs, mk, n_acc, out_n;
  int exp_blk [64];
  int exp_q [$];
  int got [64];

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int ref_val(int c, int q, int qs);
    longint p = longint'(c) * q * qs;
    longint f = (p >= 0) ? p / 16 : -((-p + 15) / 16);
    if (f > 2047) return 2047;
    if (f < -2048) return -2048;
    return int'(f);
  endfunction

  function automatic int rnd_coef();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  task automatic model_reset();
    mk = 0;
    m_qs = 0;
    for (int i = 0; i < 64; i++) m_qmat[i] = 16;
  endtask

  task automatic beat(input int c, input int qsv, input bit we = 0, input int wa = 0, input int wd = 0);
    bit acc = 0;
    int n = 0;
    int q;
    slave_tdata = 12'(c);
    slave_tvalid = 1'b1;
    qscale = 5'(qsv);
    qmat_we = we;
    qmat_addr = 6'(wa);
    qmat_data = 8'(wd);
    while (!acc) begin
      @(negedge clk);
      acc = slave_tready;
      @(posedge clk);
      if (acc) begin
        q = (mk == 0) ? qsv : m_qs;
        if (mk == 0) m_qs = qsv;
        exp_blk[zz[mk]] = ref_val(c, m_qmat[mk], q);
        mk++;
        n_acc++;
        if (mk == 64) begin
          for (int i = 0; i < 64; i++) exp_q.push_back(exp_blk[i]);
          mk = 0;
        end
      end
      if (qmat_we) m_qmat[wa] = wd;
      #1;
      qmat_we = 1'b0;
      if (++n > 1000) begin
        checks++;
        errors++;
        $error("FAIL beat_timeout: observed no acceptance expected acceptance within 1000 cycles");
        acc = 1;
      end
    end
    slave_tvalid = 1'b0;
  endtask

  task automatic wq(input int a, input int d);
    qmat_we = 1'b1;
    qmat_addr = 6'(a);
    qmat_data = 8'(d);
    @(posedge clk);
    m_qmat[a] = d;
    #1;
    qmat_we = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || master_tvalid) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (master_tvalid && master_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_beat: observed data %0d expected no beat", master_tdata);
        end else begin
          chk("beat", master_tdata, exp_q.pop_front());
          got[out_n % 64] = master_tdata;
          out_n++;
        end
      end else if (!master_tvalid) chk("idle_zero", master_tdata, 0);
    end
  end

  initial begin
    int idx = 0;
    int n, base;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) zz[idx++] = r * 8 + (s - r);
      end else begin
        for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) zz[idx++] = r * 8 + (s - r);
      end
    end
    model_reset();
    n_acc = 0;
    out_n = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_tready", slave_tready, 1);
    chk("reset_tvalid", master_tvalid, 0);
    chk("reset_tdata", master_tdata, 0);
    @(posedge clk);
    #1;

    // reorder and latency
    master_tready = 1'b1;
    for (int k = 0; k < 63; k++) beat(16 * k, 1);
    chk("valid_before_last", master_tvalid, 0);
    beat(16 * 63, 1);
    chk("valid_after_last", master_tvalid, 1);
    drain();
    chk("raster0", got[0], 0);
    chk("raster1", got[1], 16);
    chk("raster2", got[2], 80);
    chk("raster3", got[3], 96);
    chk("raster8", got[8], 32);
    chk("raster9", got[9], 64);
    chk("raster16", got[16], 48);

    // arithmetic corners
    wq(0, 255);
    beat(2047, 31);
    for (int k = 1; k < 64; k++) beat(rnd_coef(), 31);
    drain();
    chk("sat_pos", got[0], 2047);
    beat(-2048, 31);
    for (int k = 1; k < 64; k++) beat(rnd_coef(), int'($urandom_range(0, 31)));
    drain();
    chk("sat_neg", got[0], -2048);
    for (int i = 0; i < 64; i++) wq(i, 1);
    for (int k = 0; k < 64; k++) beat(-1, 1);
    drain();
    chk("floor_neg0", got[0], -1);
    chk("floor_neg63", got[63], -1);
    for (int i = 0; i < 64; i++) wq(i, 3);
    for (int k = 0; k < 64; k++) beat(5, 1);
    drain();
    chk("floor_pos", got[0], 0);
    for (int i = 0; i < 64; i++) wq(i, int'($urandom_range(0, 255)));
    for (int k = 0; k < 64; k++) beat(rnd_coef(), int'($urandom_range(0, 31)));
    drain();
    for (int i = 0; i < 64; i++) wq(i, 16);

    // backpressure over three blocks
    master_tready = 1'b0;
    n_acc = 0;
    base = out_n;
    fork
      begin
        for (int k = 0; k < 192; k++) beat(rnd_coef(), int'($urandom_range(0, 31)));
      end
      begin
        n = 0;
        while (n_acc < 128 && n < 1000) begin
          @(negedge clk);
          n++;
        end
        @(negedge clk);
        chk("bp_tready_low", slave_tready, 0);
        repeat (4) begin
          @(negedge clk);
          chk("bp_hold_valid", master_tvalid, 1);
          chk("bp_hold_data", master_tdata, exp_q.size() > 0 ? exp_q[0] : 9999);
        end
        chk("bp_stalled", n_acc, 128);
        @(posedge clk);
        #1 master_tready = 1'b1;
        repeat (63) @(posedge clk);
        @(negedge clk);
        chk("bp_last_beat_tready", slave_tready, 0);
        @(negedge clk);
        chk("bp_release_tready", slave_tready, 1);
      end
    join
    drain();
    chk("bp_count", out_n - base, 192);

    // qscale and qmat timing within a block
    beat(7, 3);
    beat(100, 9);
    for (int k = 2; k < 5; k++) beat(rnd_coef(), int'($urandom_range(0, 31)));
    beat(100, 17, 1, 5, 7);
    for (int k = 6; k < 64; k++) beat(rnd_coef(), int'($urandom_range(0, 31)));
    drain();
    chk("qs_hold", got[1], 300);
    chk("qmat_old", got[2], 300);
    beat(7, 3);
    for (int k = 1; k < 5; k++) beat(rnd_coef(), 1);
    beat(100, 1);
    for (int k = 6; k < 64; k++) beat(rnd_coef(), 1);
    drain();
    chk("qmat_new", got[2], 131);

    // reset mid-block
    for (int k = 0; k < 30; k++) beat(rnd_coef(), int'($urandom_range(0, 31)));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_mid_tready", slave_tready, 1);
    chk("rst_mid_tvalid", master_tvalid, 0);
    @(posedge clk);
    #1;
    base = out_n;
    for (int k = 0; k < 5; k++) beat(rnd_coef(), 2);
    beat(100, 2);
    for (int k = 6; k < 64; k++) beat(rnd_coef(), int'($urandom_range(0, 31)));
    drain();
    chk("rst_mid_qmat", got[2], 200);
    chk("rst_mid_count", out_n - base, 64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi_stream_dequant_zigzag.md
# axi_stream_dequant_zigzag

Upstream neighbour of the AXI-stream IDCT wrapper. It accepts 8x8 blocks of quantized coefficients in zigzag order, one per beat, and dequantizes each one with a programmable 64-entry matrix and a per-block scale. It reorders the block to raster order in a ping-pong buffer and streams 64 raster-order beats to the IDCT's slave port at one beat per cycle.

## Interface
- WCOEF, 12: signed quantized-coefficient width (slave side)
- WIN, 12: signed dequantized width (master side); equals the IDCT input width
- WQ, 8: unsigned quant-matrix entry width
- WQS, 5: unsigned quantizer-scale width
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- slave_tdata  in  WCOEF  quantized coefficient, zigzag order
- slave_tvalid  in  1  input beat valid
- slave_tready  out  1  input beat accepted when valid & ready
- qscale  in  WQS  quantizer scale; sampled on the first beat of each block
- qmat_we  in  1  quant-matrix write enable
- qmat_addr  in  6  matrix index, in zigzag order
- qmat_data  in  WQ  matrix value
- master_tdata  out  WIN  dequantized coefficient, raster order
- master_tvalid  out  1  output beat valid
- master_tready  in  1  downstream ready

## Operation
- State:
  - two banks of 64 x WIN, with flags full[1:0]
  - write-bank pointer wb and read-bank pointer rb
  - 6-bit in_cnt and out_cnt
  - a block-scale register qs_blk
  - a 64 x WQ qmat
- Input handshake at index k = in_cnt:
  - val = sat_WIN((coef * qmat[k] * qs) >>> 4), where qs = qscale if k==0, else qs_blk.
  - The product is full precision, signed 26 bits.
  - The shift is arithmetic (floor).
  - The result saturates to [-2^(WIN-1), 2^(WIN-1)-1].
  - val is written to bank[wb][ZZ[k]], where ZZ maps zigzag index to raster index.
  - in_cnt increments.
  - When k==0, qs_blk <= qscale.
- On the handshake with k==63: full[wb] <= 1, wb toggles, in_cnt wraps to 0.
- slave_tready = ~full[wb].
- master_tvalid = full[rb].
- master_tdata = bank[rb][out_cnt] while valid, else 0.
- Output handshake: out_cnt increments. At out_cnt==63: full[rb] <= 0, rb toggles, out_cnt wraps.
- qmat writes are always honoured and take effect from the next cycle.
  - A coefficient accepted in the same cycle as a write to its index uses the old value.
- Reset clears:
  - banks
  - counters
  - pointers
  - full flags
  - qs_blk
  - qmat, where every entry is set to 16 (flat: output = coef*qscale)

## Timing
- Reset values of outputs:
  - slave_tready=1
  - master_tvalid=0
  - master_tdata=0
- Latency: the 64th input handshake at edge N sets full. master_tvalid is high in the cycle following edge N, so the first output beat is available one cycle after the last input.
- Throughput:
  - one beat per cycle on each side
  - with master_tready held high and input continuous, blocks flow with no bubbles
- Both banks full: slave_tready stays low until the read side's final handshake edge; it rises in the next cycle. This single-cycle bubble is required behaviour.
- Simultaneous completion of the write bank and release of the read bank in the same cycle: both updates apply; the flags stay consistent.
- AXI rule: master_tdata and master_tvalid are held stable while valid & ~ready. slave_tdata is ignored when slave_tready is low.
- Reset asserted mid-block: the partial block is discarded. After release, the next input beat is treated as zigzag index 0.

## Structure
- Shared package `idct_pkg`:
  - WCOEF/WIN/WQ/WQS defaults
  - ZZ[0:63] zigzag-to-raster constant table
  - QMAT_RESET constant (16)
- One combinational sub-module `dequant_unit` (coef, q, qs -> sat(WIN)): multiply, arithmetic shift, saturate.

## Test plan
- Reset: hold reset for 3 cycles, then release. Expect slave_tready=1, master_tvalid=0, master_tdata=0.
- Reorder: qscale=1, flat qmat, input coefficient k = 16*k for k=0..63.
  - Raster output beats 0,1,2,3,8,9,16 carry 0,16,80,96,32,64,48, i.e. ZZ inverse x16.
  - First master_tvalid appears 1 cycle after the 64th input.
- Arithmetic:
  - coef=2047, qmat[0]=255, qscale=31 -> 2047
  - coef=-2048 -> -2048
  - coef=-1, qmat=1, qscale=1 -> -1 (floor)
  - coef=5, qmat=3, qscale=1 -> 0
- Backpressure: master_tready=0, drive 3 blocks continuously.
  - slave_tready drops after the 128th beat.
  - After master_tready=1, block 1 drains.
  - slave_tready returns 1 cycle after block 1's last beat.
  - All 192 values are correct and in order.
- qscale/qmat timing:
  - change qscale mid-block: it has no effect until the next block
  - write qmat[5] in the same cycle as beat k=5 is accepted: beat 5 uses the old value, the next block uses the new value
- Reset mid-block: after 30 input beats, pulse reset. Then send one full block: the output equals that block only, and qmat is back to 16.
